// File: rtl/axis_packet_xor_engine.sv
// Store-process-forward AXI4-Stream engine: buffers one packet, XOR-reduces it, then replays it.
// Optional build macro AXIS_XOR_APPEND_EN appends the XOR word as an extra final output beat.
module axis_packet_xor_engine #(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_DEPTH            = 8,
    parameter int unsigned C_CNT_WIDTH        = 8
) (
    input  logic                              axis_aclk,
    input  logic                              axis_aresetn,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    input  logic                              s00_axis_tlast,
    input  logic                              s00_axis_tvalid,
    output logic                              s00_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                              m00_axis_tlast,
    output logic                              m00_axis_tvalid,
    input  logic                              m00_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]     xor_result,
    output logic [C_CNT_WIDTH-1:0]            pkt_count,
    output logic [3:0]                        led
);

    localparam int unsigned W      = C_AXIS_TDATA_WIDTH;
    localparam int unsigned PTR_W  = $clog2(C_DEPTH + 1);
    localparam int unsigned ADDR_W = $clog2(C_DEPTH);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(C_DEPTH - 1);

    typedef enum logic [1:0] {
        RECV = 2'd0,
        PROC = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]           mem [C_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       len;
    logic [PTR_W-1:0]       idx;
    logic [PTR_W-1:0]       rd_ptr;
    logic [W-1:0]           acc;
    logic                   all_equal;
    logic                   truncated;

    logic                   s_hs;
    logic                   m_hs;
    logic                   pkt_end;
    logic                   proc_last;
    logic                   send_done;
    logic [W-1:0]           proc_word;
    logic [W-1:0]           acc_nxt;
    logic [W-1:0]           nxt_data;
    logic                   nxt_last;
    logic [C_CNT_WIDTH-1:0] pkt_cnt_inc;
    logic                   unused_sigs;

    assign m00_axis_tstrb = '1;
    assign unused_sigs    = ^{s00_axis_tstrb, all_equal};

    assign s_hs        = s00_axis_tvalid & s00_axis_tready;
    assign m_hs        = m00_axis_tvalid & m00_axis_tready;
    assign pkt_end     = s_hs & (s00_axis_tlast | (wr_ptr == LAST_SLOT));
    assign proc_last   = (state == PROC) && (idx == len - PTR_W'(1));
    assign send_done   = m_hs & m00_axis_tlast;
    assign proc_word   = mem[ADDR_W'(idx)];
    assign acc_nxt     = acc ^ proc_word;
    assign pkt_cnt_inc = pkt_count + C_CNT_WIDTH'(1);

    // Word presented after the current one; rd_ptr indexes the next beat to send
    always_comb begin
        nxt_data = mem[ADDR_W'(rd_ptr)];
        nxt_last = (rd_ptr == len - PTR_W'(1));
`ifdef AXIS_XOR_APPEND_EN
        nxt_last = 1'b0;
        if (rd_ptr == len) begin
            nxt_data = xor_result;
            nxt_last = 1'b1;
        end
`endif
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state <= RECV;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RECV:    if (pkt_end)   state_nxt = PROC;
            PROC:    if (proc_last) state_nxt = SEND;
            SEND:    if (send_done) state_nxt = RECV;
            default: state_nxt = RECV;
        endcase
    end

    // Packet storage carries no reset; pointers alone define valid contents
    always_ff @(posedge axis_aclk) begin
        if (s_hs) begin
            mem[ADDR_W'(wr_ptr)] <= s00_axis_tdata;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            s00_axis_tready <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tvalid <= 1'b0;
            xor_result      <= '0;
            pkt_count       <= '0;
            led             <= '0;
            wr_ptr          <= '0;
            len             <= '0;
            idx             <= '0;
            rd_ptr          <= '0;
            acc             <= '0;
            all_equal       <= 1'b0;
            truncated       <= 1'b0;
        end else begin
            s00_axis_tready <= (state_nxt == RECV);
            unique case (state)
                RECV: begin
                    if (pkt_end) begin
                        len       <= wr_ptr + PTR_W'(1);
                        truncated <= ~s00_axis_tlast;
                        wr_ptr    <= '0;
                        idx       <= '0;
                        rd_ptr    <= '0;
                        acc       <= '0;
                        all_equal <= 1'b1;
                    end else if (s_hs) begin
                        wr_ptr <= wr_ptr + PTR_W'(1);
                    end
                end
                PROC: begin
                    acc       <= acc_nxt;
                    all_equal <= all_equal & (proc_word == mem[0]);
                    idx       <= idx + PTR_W'(1);
                    if (proc_last) begin
                        xor_result      <= acc_nxt;
                        led[0]          <= (acc_nxt != '0);
                        led[1]          <= truncated;
                        m00_axis_tdata  <= nxt_data;
                        m00_axis_tlast  <= nxt_last;
                        m00_axis_tvalid <= 1'b1;
                        rd_ptr          <= rd_ptr + PTR_W'(1);
                    end
                end
                SEND: begin
                    if (send_done) begin
                        m00_axis_tvalid <= 1'b0;
                        m00_axis_tlast  <= 1'b0;
                        m00_axis_tdata  <= '0;
                        pkt_count       <= pkt_cnt_inc;
                        led[3:2]        <= pkt_cnt_inc[1:0];
                        truncated       <= 1'b0;
                    end else if (m_hs) begin
                        m00_axis_tdata <= nxt_data;
                        m00_axis_tlast <= nxt_last;
                        rd_ptr         <= rd_ptr + PTR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_packet_xor_engine.sv
// Randomised bench for axis_packet_xor_engine against a packet-level model of the store/XOR/replay rules.
module tb_axis_packet_xor_engine;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 8;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    typedef struct {
        logic [W-1:0] x;
        logic         trunc;
        int           len;
        int           commit_cyc;
    } pkt_t;

    logic            axis_aclk = 1'b0;
    logic            axis_aresetn = 1'b0;
    logic [W-1:0]    s00_axis_tdata = '0;
    logic [W/8-1:0]  s00_axis_tstrb = '1;
    logic            s00_axis_tlast = 1'b0;
    logic            s00_axis_tvalid = 1'b0;
    logic            s00_axis_tready;
    logic [W-1:0]    m00_axis_tdata;
    logic [W/8-1:0]  m00_axis_tstrb;
    logic            m00_axis_tlast;
    logic            m00_axis_tvalid;
    logic            m00_axis_tready = 1'b0;
    logic [W-1:0]    xor_result;
    logic [CW-1:0]   pkt_count;
    logic [3:0]      led;

    axis_packet_xor_engine #(
        .C_AXIS_TDATA_WIDTH(W),
        .C_DEPTH(DEPTH),
        .C_CNT_WIDTH(CW)
    ) dut (
        .axis_aclk(axis_aclk),
        .axis_aresetn(axis_aresetn),
        .s00_axis_tdata(s00_axis_tdata),
        .s00_axis_tstrb(s00_axis_tstrb),
        .s00_axis_tlast(s00_axis_tlast),
        .s00_axis_tvalid(s00_axis_tvalid),
        .s00_axis_tready(s00_axis_tready),
        .m00_axis_tdata(m00_axis_tdata),
        .m00_axis_tstrb(m00_axis_tstrb),
        .m00_axis_tlast(m00_axis_tlast),
        .m00_axis_tvalid(m00_axis_tvalid),
        .m00_axis_tready(m00_axis_tready),
        .xor_result(xor_result),
        .pkt_count(pkt_count),
        .led(led)
    );

    always #5 axis_aclk = ~axis_aclk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int gap_pct = 0;
    int out_mode = 0;
    int out_idx = 0;

    beat_t        in_q[$];
    logic [W-1:0] cur_pkt[$];
    beat_t        exp_q[$];
    pkt_t         pkt_q[$];
    logic [CW-1:0] model_cnt = '0;

    logic         hs_in = 1'b0;
    logic         hs_out = 1'b0;
    logic         prev_valid = 1'b0;
    logic         prev_ready = 1'b0;
    logic         prev_last = 1'b0;
    logic [W-1:0] prev_data = '0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_beat(input logic [W-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        in_q.push_back(b);
    endtask

    // A closed input packet becomes an expected output beat list plus its XOR/truncation record
    task automatic commit(input logic trunc);
        pkt_t         p;
        beat_t        e;
        logic [W-1:0] x;
        x = '0;
        foreach (cur_pkt[i]) x = x ^ cur_pkt[i];
        foreach (cur_pkt[i]) begin
            e.data = cur_pkt[i];
            e.last = (i == cur_pkt.size() - 1);
`ifdef AXIS_XOR_APPEND_EN
            e.last = 1'b0;
`endif
            exp_q.push_back(e);
        end
`ifdef AXIS_XOR_APPEND_EN
        e.data = x;
        e.last = 1'b1;
        exp_q.push_back(e);
`endif
        p.x          = x;
        p.trunc      = trunc;
        p.len        = cur_pkt.size();
        p.commit_cyc = cyc;
        pkt_q.push_back(p);
        cur_pkt.delete();
    endtask

    task automatic compare_cycle();
        chk("s_tready", W'(s00_axis_tready), W'(pkt_q.size() == 0));
        chk("pkt_count", W'(pkt_count), W'(model_cnt));
        chk("led_cnt", W'(led[3:2]), W'(model_cnt[1:0]));
        if (pkt_q.size() == 0) chk("tvalid_idle", W'(m00_axis_tvalid), '0);
        if (prev_valid && !prev_ready) begin
            chk("stall_valid", W'(m00_axis_tvalid), W'(1'b1));
            chk("stall_data", m00_axis_tdata, prev_data);
            chk("stall_last", W'(m00_axis_tlast), W'(prev_last));
        end else if (hs_out && !prev_last) begin
            chk("no_bubble", W'(m00_axis_tvalid), W'(1'b1));
        end
        if (m00_axis_tvalid && !prev_valid && pkt_q.size() != 0)
            chk("proc_latency", W'(cyc - pkt_q[0].commit_cyc), W'(pkt_q[0].len + 1));
    endtask

    task automatic drive_cycle();
        beat_t b;
        if (!s00_axis_tvalid || hs_in) begin
            if (in_q.size() != 0 && int'($urandom_range(99)) >= gap_pct) begin
                b = in_q.pop_front();
                s00_axis_tvalid = 1'b1;
                s00_axis_tdata  = b.data;
                s00_axis_tlast  = b.last;
            end else begin
                s00_axis_tvalid = 1'b0;
                s00_axis_tdata  = $urandom;
                s00_axis_tlast  = 1'b0;
            end
        end
        case (out_mode)
            0:       m00_axis_tready = 1'b1;
            1:       m00_axis_tready = (cyc % 2 == 0);
            default: m00_axis_tready = ($urandom_range(99) < 60);
        endcase
    endtask

    task automatic account_cycle();
        beat_t e;
        hs_in = s00_axis_tvalid && s00_axis_tready;
        if (hs_in) begin
            cur_pkt.push_back(s00_axis_tdata);
            if (s00_axis_tlast || cur_pkt.size() == DEPTH) commit(!s00_axis_tlast);
        end
        hs_out = m00_axis_tvalid && m00_axis_tready;
        if (hs_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got 0x%0h expected no beat", m00_axis_tdata);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", m00_axis_tdata, e.data);
                chk("out_last", W'(m00_axis_tlast), W'(e.last));
                if (out_idx == 0 && pkt_q.size() != 0) begin
                    chk("xor_result", xor_result, pkt_q[0].x);
                    chk("led_status", W'(led[1:0]), W'({pkt_q[0].trunc, pkt_q[0].x != '0}));
                end
                out_idx++;
                if (e.last) begin
                    out_idx = 0;
                    if (pkt_q.size() != 0) void'(pkt_q.pop_front());
                    model_cnt = model_cnt + CW'(1);
                end
            end
        end
        prev_valid = m00_axis_tvalid;
        prev_ready = m00_axis_tready;
        prev_data  = m00_axis_tdata;
        prev_last  = m00_axis_tlast;
    endtask

    // Per-cycle driver/model/compare loop, everything done on the falling edge
    initial begin
        forever begin
            @(negedge axis_aclk);
            cyc++;
            if (!axis_aresetn) begin
                s00_axis_tvalid = 1'b0;
                s00_axis_tlast  = 1'b0;
                s00_axis_tdata  = '0;
                m00_axis_tready = 1'b0;
                in_q.delete();
                cur_pkt.delete();
                exp_q.delete();
                pkt_q.delete();
                model_cnt  = '0;
                hs_in      = 1'b0;
                hs_out     = 1'b0;
                prev_valid = 1'b0;
                prev_ready = 1'b0;
                prev_last  = 1'b0;
                prev_data  = '0;
                out_idx    = 0;
            end else begin
                compare_cycle();
                drive_cycle();
                account_cycle();
            end
        end
    end

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((in_q.size() != 0 || cur_pkt.size() != 0 || pkt_q.size() != 0 || s00_axis_tvalid)
               && n < budget) begin
            @(negedge axis_aclk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s_timeout: got %0d cycles expected < %0d", name, n, budget);
        end
        repeat (3) @(negedge axis_aclk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, W'(m00_axis_tvalid), '0);
        chk({tag, "_tlast"}, W'(m00_axis_tlast), '0);
        chk({tag, "_tdata"}, m00_axis_tdata, '0);
        chk({tag, "_tready"}, W'(s00_axis_tready), '0);
        chk({tag, "_xor"}, xor_result, '0);
        chk({tag, "_cnt"}, W'(pkt_count), '0);
        chk({tag, "_led"}, W'(led), '0);
        chk({tag, "_tstrb"}, W'(m00_axis_tstrb), W'(4'hF));
    endtask

    task automatic do_reset();
        @(posedge axis_aclk);
        #2 axis_aresetn = 1'b0;
        #1 check_reset_outputs("rst_async");
        repeat (2) @(negedge axis_aclk);
        #2 axis_aresetn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int           n;
        int           plen;
        logic         same;
        logic [W-1:0] word;

        repeat (2) @(negedge axis_aclk);
        check_reset_outputs("rst_init");
        #2 axis_aresetn = 1'b1;
        repeat (2) @(negedge axis_aclk);

        // Eight words 1..8 closed by tlast
        gap_pct  = 0;
        out_mode = 0;
        for (int i = 0; i < 8; i++) push_beat(W'(i + 1), i == 7);
        wait_idle("t1", 200);
        chk("t1_xor", xor_result, 32'h8);
        chk("t1_led", W'(led), W'(4'b0101));
        chk("t1_cnt", W'(pkt_count), W'(1));

        // Four identical words cancel to zero
        for (int i = 0; i < 4; i++) push_beat(32'hA5A5_A5A5, i == 3);
        wait_idle("t2", 200);
        chk("t2_xor", xor_result, '0);
        chk("t2_led", W'(led), W'(4'b1000));
        chk("t2_cnt", W'(pkt_count), W'(2));

        // Ten beats with no early tlast: truncated 8-beat packet then a 2-beat packet
        for (int i = 0; i < 10; i++) push_beat(W'(i + 1), i == 9);
        n = 0;
        while (!m00_axis_tvalid && n < 200) begin
            @(negedge axis_aclk);
            n++;
        end
        chk("t3_wait_tvalid", W'(m00_axis_tvalid), W'(1'b1));
        chk("t3_trunc_xor", xor_result, 32'h8);
        chk("t3_trunc_led", W'(led[1:0]), W'(2'b11));
        wait_idle("t3", 300);
        chk("t3_xor", xor_result, 32'h3);
        chk("t3_cnt", W'(pkt_count), W'(4));
        chk("t3_led", W'(led), W'(4'b0001));

        // Single-word packet
        push_beat(32'hDEAD_BEEF, 1'b1);
        wait_idle("t4", 100);
        chk("t4_xor", xor_result, 32'hDEAD_BEEF);
        chk("t4_cnt", W'(pkt_count), W'(5));
        chk("t4_led", W'(led), W'(4'b0101));

        // Alternating output ready
        out_mode = 1;
        for (int i = 0; i < 6; i++) push_beat($urandom, i == 5);
        for (int i = 0; i < 3; i++) push_beat($urandom, i == 2);
        wait_idle("t5", 300);
        chk("t5_cnt", W'(pkt_count), W'(7));

        // Reset after a few input beats, then a clean packet
        out_mode = 0;
        for (int i = 0; i < 8; i++) push_beat($urandom, i == 7);
        n = 0;
        while (cur_pkt.size() < 3 && n < 100) begin
            @(negedge axis_aclk);
            n++;
        end
        do_reset();
        repeat (2) @(negedge axis_aclk);
        for (int i = 0; i < 8; i++) push_beat(32'h1111_1111 * W'(i + 1), i == 7);
        wait_idle("t6", 200);
        chk("t6_cnt", W'(pkt_count), W'(1));
        chk("t6_xor", xor_result, 32'h8888_8888);
        chk("t6_led", W'(led), W'(4'b0101));

        // Random packets, random gaps and back-pressure
        gap_pct  = 30;
        out_mode = 2;
        for (int p = 0; p < 40; p++) begin
            plen = int'($urandom_range(12, 1));
            same = ($urandom_range(3) == 0);
            word = $urandom;
            for (int i = 0; i < plen; i++) push_beat(same ? word : W'($urandom), i == plen - 1);
        end
        wait_idle("t7", 20000);

        // Counter wrap over 256 single-word packets
        do_reset();
        repeat (2) @(negedge axis_aclk);
        gap_pct  = 0;
        out_mode = 0;
        for (int p = 0; p < 256; p++) push_beat(W'(p + 1), 1'b1);
        wait_idle("t8", 5000);
        chk("t8_cnt_wrap", W'(pkt_count), '0);
        chk("t8_led_cnt", W'(led[3:2]), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
